// File: rtl/if_id_buffer.sv
// if_id_buffer: two-entry elastic buffer between instruction fetch and decode.
// It holds {pc, instr} pairs and presents the oldest one to decode.
// A flush empties the buffer so decode sees a NOP bubble.
module if_id_buffer #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_valid,
    input  logic [15:0] fetch_pc,
    input  logic [15:0] fetch_instr,
    input  logic        flush,
    input  logic        decode_ready,
    output logic        fetch_ready,
    output logic        id_valid,
    output logic [15:0] id_pc,
    output logic [15:0] id_pc_plus2,
    output logic [15:0] id_instr,
    output logic [1:0]  occupancy
);

    localparam int unsigned W        = 16;
    localparam logic [1:0]  CNT_FULL = 2'(DEPTH);

    typedef struct packed {
        logic [W-1:0] pc;
        logic [W-1:0] instr;
    } entry_t;

    entry_t      mem_q [2];
    entry_t      mem_d [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;

    logic        enq;
    logic        deq;
    entry_t      head;

    // Handshake qualifiers; fetch_ready depends only on the registered count.
    always_comb begin
        fetch_ready = (count_q != CNT_FULL);
        id_valid    = (count_q != 2'd0);
        head        = mem_q[rd_ptr_q];
        enq         = fetch_valid & fetch_ready & ~flush;
        deq         = id_valid & decode_ready & ~flush;
    end

    // Head presentation, muxed to the bubble values when empty.
    always_comb begin
        id_pc       = id_valid ? head.pc    : W'(0);
        id_instr    = id_valid ? head.instr : NOP_WORD;
        id_pc_plus2 = id_pc + W'(2);
        occupancy   = count_q;
    end

    // Next-state: flush clears pointers and count, otherwise enq/deq update.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (enq) begin
                mem_d[wr_ptr_q] = '{pc: fetch_pc, instr: fetch_instr};
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (deq) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// Testbench for if_id_buffer: directed vector table, a wrap/ordering stream,
// then random traffic against a queue-based reference model.
module tb_if_id_buffer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_valid;
    logic [15:0] fetch_pc;
    logic [15:0] fetch_instr;
    logic        flush;
    logic        decode_ready;
    logic        fetch_ready;
    logic        id_valid;
    logic [15:0] id_pc;
    logic [15:0] id_pc_plus2;
    logic [15:0] id_instr;
    logic [1:0]  occupancy;

    int total = 0;
    int bad   = 0;

    if_id_buffer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .fetch_valid  (fetch_valid),
        .fetch_pc     (fetch_pc),
        .fetch_instr  (fetch_instr),
        .flush        (flush),
        .decode_ready (decode_ready),
        .fetch_ready  (fetch_ready),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_pc_plus2  (id_pc_plus2),
        .id_instr     (id_instr),
        .occupancy    (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        fv;
        logic [15:0] pc;
        logic [15:0] instr;
        logic        fl;
        logic        dr;
        logic [1:0]  e_occ;
        logic        e_v;
        logic [15:0] e_pc;
        logic [15:0] e_instr;
        logic        e_fr;
    } vec_t;

    vec_t vecs[$];

    // Reference model: FIFO of {pc, instr}
    logic [31:0] mq[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic fv, input logic [15:0] pc, input logic [15:0] ins,
                       input logic fl, input logic dr, input logic [1:0] eo, input logic ev,
                       input logic [15:0] epc, input logic [15:0] ei, input logic efr);
        vec_t v;
        v.rst_n = r; v.fv = fv; v.pc = pc; v.instr = ins; v.fl = fl; v.dr = dr;
        v.e_occ = eo; v.e_v = ev; v.e_pc = epc; v.e_instr = ei; v.e_fr = efr;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic fv, input logic [15:0] pc, input logic [15:0] ins,
                         input logic fl, input logic dr);
        reset_n = r; fetch_valid = fv; fetch_pc = pc; fetch_instr = ins; flush = fl; decode_ready = dr;
    endtask

    // Compare DUT outputs against the model's current contents.
    task automatic check_model(input string tag);
        logic [15:0] epc, ei;
        epc = (mq.size() > 0) ? mq[0][31:16] : 16'h0000;
        ei  = (mq.size() > 0) ? mq[0][15:0]  : 16'h0000;
        chk({tag, "_occ"},   16'(occupancy),   16'(mq.size()));
        chk({tag, "_valid"}, 16'(id_valid),    16'(mq.size() > 0));
        chk({tag, "_pc"},    id_pc,            epc);
        chk({tag, "_pc2"},   id_pc_plus2,      epc + 16'd2);
        chk({tag, "_instr"}, id_instr,         ei);
        chk({tag, "_fready"},16'(fetch_ready), 16'(mq.size() != 2));
    endtask

    // One clock with model update; outputs checked before the edge.
    task automatic do_cycle(input string tag, input logic r, input logic fv, input logic [15:0] pc,
                            input logic [15:0] ins, input logic fl, input logic dr);
        bit e, d;
        drive(r, fv, pc, ins, fl, dr);
        check_model(tag);
        @(posedge clk);
        #1;
        if (!r || fl) begin
            mq.delete();
        end else begin
            e = fv && (mq.size() < 2);
            d = dr && (mq.size() > 0);
            if (d) void'(mq.pop_front());
            if (e) mq.push_back({pc, ins});
        end
    endtask

    initial begin
        logic [15:0] sent [6];
        int          wi, rk;
        logic        dr;

        drive(1'b0, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);

        //   rst fv  pc        instr     fl   dr   occ  v    id_pc     id_instr  fr
        add(1'b0, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        add(1'b0, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        add(1'b1, 1'b1, 16'h3000, 16'h1261, 1'b0, 1'b1, 2'd1, 1'b1, 16'h3000, 16'h1261, 1'b1);
        add(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 2'd0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        add(1'b1, 1'b1, 16'h3000, 16'h000A, 1'b0, 1'b0, 2'd1, 1'b1, 16'h3000, 16'h000A, 1'b1);
        add(1'b1, 1'b1, 16'h3002, 16'h000B, 1'b0, 1'b0, 2'd2, 1'b1, 16'h3000, 16'h000A, 1'b0);
        add(1'b1, 1'b1, 16'h3004, 16'h000C, 1'b0, 1'b0, 2'd2, 1'b1, 16'h3000, 16'h000A, 1'b0);
        add(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 2'd1, 1'b1, 16'h3002, 16'h000B, 1'b1);
        add(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 2'd0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        add(1'b1, 1'b1, 16'h5000, 16'h000D, 1'b0, 1'b0, 2'd1, 1'b1, 16'h5000, 16'h000D, 1'b1);
        add(1'b1, 1'b1, 16'h5002, 16'h000E, 1'b0, 1'b0, 2'd2, 1'b1, 16'h5000, 16'h000D, 1'b0);
        add(1'b1, 1'b1, 16'h5004, 16'h000F, 1'b0, 1'b1, 2'd1, 1'b1, 16'h5002, 16'h000E, 1'b1);
        add(1'b1, 1'b1, 16'h5004, 16'h000F, 1'b0, 1'b1, 2'd1, 1'b1, 16'h5004, 16'h000F, 1'b1);
        add(1'b1, 1'b1, 16'h5006, 16'h0010, 1'b0, 1'b0, 2'd2, 1'b1, 16'h5004, 16'h000F, 1'b0);
        add(1'b1, 1'b1, 16'h6000, 16'h0011, 1'b1, 1'b1, 2'd0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        add(1'b1, 1'b1, 16'h4000, 16'h0012, 1'b0, 1'b0, 2'd1, 1'b1, 16'h4000, 16'h0012, 1'b1);
        add(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 2'd0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        add(1'b1, 1'b1, 16'h7000, 16'h0013, 1'b0, 1'b0, 2'd1, 1'b1, 16'h7000, 16'h0013, 1'b1);
        add(1'b0, 1'b1, 16'h7002, 16'h0014, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        add(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 16'h0000, 1'b1);

        // Directed table
        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].fv, vecs[i].pc, vecs[i].instr, vecs[i].fl, vecs[i].dr);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_occ", i),    16'(occupancy),   16'(vecs[i].e_occ));
            chk($sformatf("v%0d_valid", i),  16'(id_valid),    16'(vecs[i].e_v));
            chk($sformatf("v%0d_pc", i),     id_pc,            vecs[i].e_pc);
            chk($sformatf("v%0d_pc2", i),    id_pc_plus2,      vecs[i].e_pc + 16'd2);
            chk($sformatf("v%0d_instr", i),  id_instr,         vecs[i].e_instr);
            chk($sformatf("v%0d_fready", i), 16'(fetch_ready), 16'(vecs[i].e_fr));
        end

        // Wrap: 6 words, decode_ready toggling, order must be preserved
        mq.delete();
        for (int i = 0; i < 6; i++) sent[i] = 16'hA000 + 16'(i * 3 + 1);
        wi = 0;
        rk = 0;
        dr = 1'b0;
        for (int c = 0; c < 30 && rk < 6; c++) begin
            if (id_valid && dr) begin
                chk("wrap_order", id_instr, sent[rk]);
                rk++;
            end
            chk("wrap_occ_le2", 16'(occupancy <= 2'd2), 16'd1);
            if (wi < 6) begin
                if (fetch_ready) begin
                    do_cycle("wrap", 1'b1, 1'b1, 16'h8000 + 16'(wi * 2), sent[wi], 1'b0, dr);
                    wi++;
                end else begin
                    do_cycle("wrap", 1'b1, 1'b1, 16'h8000 + 16'(wi * 2), sent[wi], 1'b0, dr);
                end
            end else begin
                do_cycle("wrap", 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, dr);
            end
            dr = ~dr;
        end
        chk("wrap_count", 16'(rk), 16'd6);

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            logic        r, fv, fl, d;
            logic [15:0] pc;
            r  = ($urandom_range(0, 39) != 0);
            fv = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 9) == 0);
            d  = ($urandom_range(0, 1) == 1);
            pc = ($urandom_range(0, 7) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1)) : 16'($urandom);
            do_cycle("rnd", r, fv, pc, 16'($urandom), fl, d);
        end
        check_model("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
